// File: rtl/cmp_stream_pipe.sv
// Two-stage streaming comparator with mismatch statistics.
// Define CMP_STREAM_SIGNED_EN to enable signed LT (110) and signed GT (111).
module cmp_stream_pipe #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_hit,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b
);

  // Handshake: a beat moves on an edge where valid && ready; valid is held
  // with stable data until taken, and ready never depends on valid.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_mode;

  logic             s2_valid;
  logic             s2_s;
  logic             s2_ne;
  logic [WIDTH-1:0] s2_a;
  logic [WIDTH-1:0] s2_b;

  logic adv1;
  logic adv2;
  logic transfer;
  logic rel;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign transfer  = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign s         = s2_s;

  always_comb begin
    rel = 1'b0;
    case (s1_mode)
      3'b000:  rel = (s1_a == s1_b);
      3'b001:  rel = (s1_a != s1_b);
      3'b010:  rel = (s1_a <  s1_b);
      3'b011:  rel = (s1_a <= s1_b);
      3'b100:  rel = (s1_a >  s1_b);
      3'b101:  rel = (s1_a >= s1_b);
`ifdef CMP_STREAM_SIGNED_EN
      3'b110:  rel = ($signed(s1_a) < $signed(s1_b));
      3'b111:  rel = ($signed(s1_a) > $signed(s1_b));
`endif
      default: rel = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_mode <= mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_s     <= 1'b0;
      s2_ne    <= 1'b0;
      s2_a     <= '0;
      s2_b     <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_s  <= rel;
        s2_ne <= (s1_a != s1_b);
        s2_a  <= s1_a;
        s2_b  <= s1_b;
      end
    end
  end

  // clear wins over a coincident mismatching transfer, which is then lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_cnt <= '0;
      first_hit    <= 1'b0;
      first_a      <= '0;
      first_b      <= '0;
    end else if (clear) begin
      mismatch_cnt <= '0;
      first_hit    <= 1'b0;
      first_a      <= '0;
      first_b      <= '0;
    end else if (transfer && s2_ne) begin
      if (mismatch_cnt != {CNT_W{1'b1}}) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      if (!first_hit) begin
        first_hit <= 1'b1;
        first_a   <= s2_a;
        first_b   <= s2_b;
      end
    end
  end

endmodule

// File: tb/tb_cmp_stream_pipe.sv
// Bench for cmp_stream_pipe: constant vector tables, corner sequences and a
// random stream checked against a queue-based reference model.
module tb_cmp_stream_pipe;
  localparam int W     = 5;
  localparam int CNT_W = 2;
`ifdef CMP_STREAM_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2:0]       mode;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic             s;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             first_hit;
  logic [W-1:0]     first_a;
  logic [W-1:0]     first_b;

  cmp_stream_pipe #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .mismatch_cnt(mismatch_cnt),
    .first_hit(first_hit), .first_a(first_a), .first_b(first_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   mode;
    int           age;
    logic         tbl;
    logic         tbl_s;
  } ent_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   mode;
    logic         exp_s;
  } vec_t;

  ent_t exp_q[$];
  int   m_cnt;
  logic m_hit;
  logic [W-1:0] m_fa;
  logic [W-1:0] m_fb;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic ref_rel(logic [W-1:0] x, logic [W-1:0] y, logic [2:0] m);
    case (m)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd2: return x < y;
      3'd3: return x <= y;
      3'd4: return x > y;
      3'd5: return x >= y;
      3'd6: return SIGNED_EN && ($signed(x) < $signed(y));
      default: return SIGNED_EN && ($signed(x) > $signed(y));
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0;
    m_hit = 1'b0;
    m_fa  = '0;
    m_fb  = '0;
  endtask

  // One clock cycle: drive, check against the model, let the edge pass, update.
  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [2:0] im, input logic ordy, input logic clr,
                      input logic tbl, input logic tbl_s,
                      output logic acc, output logic dut_acc);
    logic e_ir, e_ov, xfer;
    ent_t e;
    in_valid = iv; a = ia; b = ib; mode = im; out_ready = ordy; clear = clr;
    #1;
    e_ir = (exp_q.size() < 2) || ordy;
    e_ov = (exp_q.size() > 0) && (exp_q[0].age >= 1);
    check("in_ready", 32'(in_ready), 32'(e_ir));
    check("out_valid", 32'(out_valid), 32'(e_ov));
    if (e_ov) begin
      check("s_model", 32'(s), 32'(ref_rel(exp_q[0].a, exp_q[0].b, exp_q[0].mode)));
      if (exp_q[0].tbl) check("s_table", 32'(s), 32'(exp_q[0].tbl_s));
    end
    check("mismatch_cnt", 32'(mismatch_cnt), 32'(m_cnt));
    check("first_hit", 32'(first_hit), 32'(m_hit));
    check("first_a", 32'(first_a), 32'(m_fa));
    check("first_b", 32'(first_b), 32'(m_fb));
    acc     = iv && e_ir;
    dut_acc = iv && in_ready;
    xfer    = e_ov && ordy;
    @(posedge clk);
    if (clr) begin
      m_cnt = 0; m_hit = 1'b0; m_fa = '0; m_fb = '0;
    end else if (xfer && (exp_q[0].a != exp_q[0].b)) begin
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (!m_hit) begin
        m_hit = 1'b1; m_fa = exp_q[0].a; m_fb = exp_q[0].b;
      end
    end
    if (xfer) void'(exp_q.pop_front());
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i]; e.age = e.age + 1; exp_q[i] = e;
    end
    if (acc) begin
      e.a = ia; e.b = ib; e.mode = im; e.age = 0; e.tbl = tbl; e.tbl_s = tbl_s;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic x, y;
    step(1'b0, '0, '0, 3'd0, ordy, clr, 1'b0, 1'b0, x, y);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1, 1'b0);
  endtask

  task automatic run_table(input vec_t v[$]);
    logic x, y;
    foreach (v[i]) step(1'b1, v[i].a, v[i].b, v[i].mode, 1'b1, 1'b0, 1'b1, v[i].exp_s, x, y);
    drain();
  endtask

  vec_t neq_v[$];
  vec_t rel_v[$];
  vec_t bp_v[$];

  initial begin
    logic acc, dacc;
    int   idx, n_dacc;
    logic iv;
    logic [W-1:0] ra, rb;
    logic [2:0]   rm;

    neq_v = '{'{5'h0A, 5'h0A, 3'd1, 1'b0}, '{5'h0A, 5'h0B, 3'd1, 1'b1},
              '{5'h1F, 5'h0F, 3'd1, 1'b1}};
    rel_v = '{'{5'h1F, 5'h0F, 3'd2, 1'b0}, '{5'h1F, 5'h0F, 3'd3, 1'b0},
              '{5'h1F, 5'h0F, 3'd4, 1'b1}, '{5'h1F, 5'h0F, 3'd5, 1'b1},
              '{5'h1F, 5'h0F, 3'd0, 1'b0}, '{5'h07, 5'h07, 3'd3, 1'b1},
              '{5'h07, 5'h07, 3'd5, 1'b1}, '{5'h07, 5'h07, 3'd2, 1'b0},
              '{5'h1F, 5'h01, 3'd6, SIGNED_EN}, '{5'h1F, 5'h01, 3'd7, 1'b0}};
    bp_v  = '{'{5'h01, 5'h02, 3'd1, 1'b1}, '{5'h03, 5'h03, 3'd0, 1'b1},
              '{5'h1F, 5'h00, 3'd4, 1'b1}, '{5'h10, 5'h11, 3'd2, 1'b1}};

    // Reset values, checked while rst is still asserted.
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = '0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cnt", 32'(mismatch_cnt), 32'd0);
    check("rst_first_hit", 32'(first_hit), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // NEQ stream, results two cycles after accept.
    run_table(neq_v);
    check("neq_cnt", 32'(mismatch_cnt), 32'd2);
    check("neq_first_a", 32'(first_a), 32'h0A);
    check("neq_first_b", 32'(first_b), 32'h0B);

    run_table(rel_v);

    // Backpressure: four pairs offered against a stalled consumer.
    idx = 0; n_dacc = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, bp_v[idx].a, bp_v[idx].b, bp_v[idx].mode, 1'b0, 1'b0, 1'b0, 1'b0, acc, dacc);
      if (dacc) n_dacc++;
      if (acc) idx++;
    end
    out_ready = 1'b0; in_valid = 1'b1; #1;
    check("bp_accepted", 32'(n_dacc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 20 && idx < 4; k++) begin
      step(1'b1, bp_v[idx].a, bp_v[idx].b, bp_v[idx].mode, 1'b1, 1'b0, 1'b0, 1'b0, acc, dacc);
      if (acc) idx++;
    end
    check("bp_all_accepted", 32'(idx), 32'd4);
    drain();

    // Saturation at 3 and clear coincident with a counted transfer.
    idle(1'b1, 1'b1);
    for (int k = 0; k < 5; k++)
      step(1'b1, W'(k), W'(k + 1), 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, acc, dacc);
    drain();
    check("sat_cnt", 32'(mismatch_cnt), 32'd3);
    step(1'b1, 5'h04, 5'h09, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, acc, dacc);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    check("clr_cnt", 32'(mismatch_cnt), 32'd0);
    check("clr_first_hit", 32'(first_hit), 32'd0);
    check("clr_first_a", 32'(first_a), 32'd0);

    // Reset with two pairs stalled in flight.
    step(1'b1, 5'h02, 5'h05, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, acc, dacc);
    step(1'b1, 5'h06, 5'h01, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, acc, dacc);
    in_valid = 1'b0; rst = 1'b1; #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(mismatch_cnt), 32'd0);
    check("mid_rst_first_hit", 32'(first_hit), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) idle(1'b1, 1'b0);

    // Random stream; an offered pair is held until accepted.
    iv = 1'b0; ra = '0; rb = '0; rm = '0;
    for (int k = 0; k < 600; k++) begin
      if (!iv) begin
        iv = ($urandom_range(0, 3) != 0);
        ra = W'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
        rm = 3'($urandom_range(0, 7));
      end
      step(iv, ra, rb, rm, ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
           1'b0, 1'b0, acc, dacc);
      if (acc) iv = 1'b0;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cmp_stream_pipe.md
# cmp_stream_pipe

Parametrised, pipelined streaming comparator: accepts operand pairs over a valid/ready handshake, evaluates a selectable relation (EQ, NEQ, LT, LE, GT, GE) at WIDTH bits, and returns a registered one-bit result two cycles later.
- Tracks a saturating count of unequal pairs and captures the first unequal pair seen since reset or clear.
- Sits between operand producers and the result consumer in the guide's datapath exercises.
- Generalises the fixed 5-bit combinational inequality check to arbitrary width, multiple relations and a flow-controlled stream.

## Interface
- WIDTH, 5, operand width in bits (≥1)
- CNT_W, 8, mismatch counter width (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block accepts pair this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- mode  input  3  relation select, sampled with the pair
- clear  input  1  synchronous clear of statistics
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result this cycle
- s  output  1  comparison result
- mismatch_cnt  output  CNT_W  saturating count of delivered pairs with a≠b
- first_hit  output  1  a mismatch has been captured
- first_a  output  WIDTH  A of first captured mismatch
- first_b  output  WIDTH  B of first captured mismatch

## Operation
- Modes: 000 EQ, 001 NEQ, 010 LT, 011 LE, 100 GT, 101 GE; all unsigned. 110/111 per Configuration.
- Reserved modes produce s=0. They still flow and count normally.
- Stage 1 registers a, b and mode on accept, where accept = in_valid && in_ready.
- Stage 2 registers s, the a≠b flag and the operands.
- Stage 2 output drives out_valid and s.
- Pipeline advance:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1, purely combinational from state and out_ready.
- Transfer = out_valid && out_ready. On a transfer whose a≠b:
  - mismatch_cnt increments, saturating at 2^CNT_W−1.
  - If first_hit=0: set first_hit=1, load first_a/first_b.
- Statistics depend only on a≠b, never on mode.
- clear zeroes mismatch_cnt, first_hit, first_a and first_b next edge.
- clear has priority over a coincident counted transfer; that transfer is not counted.
- clear does not affect pipeline contents.
- Results are delivered strictly in acceptance order. Nothing is dropped or duplicated.

## Timing
- Reset values: out_valid=0, s=0, mismatch_cnt=0, first_hit=0, first_a=0, first_b=0, both stage valids 0. in_ready=1 during and after reset.
- Reset mid-operation discards all in-flight pairs immediately (asynchronous).
- Latency: with out_ready held high, a pair accepted at edge N appears with out_valid=1 after edge N+1. It transfers on edge N+2.
- Throughput: one pair per cycle with out_ready=1.
- Backpressure:
  - With out_ready=0, two pairs may be held.
  - in_ready falls once both stages are full.
  - s and out_valid stay stable while stalled.
- Accept and deliver in the same cycle is legal when full and out_ready=1; no bubble.
- Statistics update on the edge of the transfer and are visible the following cycle.

## Configuration
- Macro: CMP_STREAM_SIGNED_EN.
- Defined: 110 = signed LT and 111 = signed GT, with two's-complement operands of WIDTH bits.
- Undefined: 110/111 are reserved and give s=0; no signed logic is synthesised.
- Ports and latency are identical in both builds.

## Test plan
- Reset: stall output with out_ready=0 and two pairs in flight, pulse rst → out_valid=0, mismatch_cnt=0, first_hit=0, in_ready=1; no stale result emerges afterwards.
- NEQ stream, WIDTH=5, out_ready=1, three consecutive cycles:
  - (0x0A,0x0A) → s=0
  - (0x0A,0x0B) → s=1
  - (0x1F,0x0F) → s=1
  - Each result arrives 2 cycles after accept.
  - Final state: mismatch_cnt=2, first_a=0x0A, first_b=0x0B.
- Relations on (0x1F,0x0F): LT→0, LE→0, GT→1, GE→1, EQ→0. On (0x07,0x07): LE→1, GE→1, LT→0.
- Backpressure: hold out_ready=0 while offering 4 pairs → exactly 2 accepted, in_ready=0. Release → results in order, each s stable while stalled, remaining pairs then accepted.
- Saturation/clear, CNT_W=2:
  - 5 mismatching transfers → mismatch_cnt=3.
  - clear coincident with a mismatching transfer → mismatch_cnt=0, first_hit=0.
- Signed build: mode 110 with a=0x1F, b=0x01 → s=1 with CMP_STREAM_SIGNED_EN; s=0 without it. Mode 111 on the same pair → s=0 in both builds.
